layer3_window_fetcher: RTL and testbench
========================================

// Module: layer3_window_fetcher
// PURPOSE
// - Consumer of the layer2 result one-side memory (14x14 grid, one 128-bit word per pixel).
// - Walks every KxK conv window of the layer2 map in raster order, issuing one SRAM read per pixel.
// - Streams the window pixels to the layer3 conv engine over a valid/ready interface.
// - Sequenced by a start/done pair from the top-level controller.
// PARAMETERS
// - IMG_W   14   layer2 map width = height, in pixels
// - K       3    window size
// - DATA_W  128  pixel word width (= LAYER2_OUTPUT_LENGTH)
// PORTS
// - clk               in   1       single clock, rising edge
// - rst               in   1       asynchronous, active-low reset
// - start             in   1       1-cycle pulse: begin a full map pass
// - busy              out  1       high from start accept to done
// - done              out  1       1-cycle pulse after last pixel handshake
// - read_row_addr     out  16      row to memory read port
// - read_col_addr     out  16      col to memory read port
// - layer2_result_read_signal out 1  read enable; data valid on mem_rdata next cycle
// - mem_rdata         in   DATA_W  memory read data (layer2_result_output)
// - out_valid         out  1       pixel word available
// - out_ready         in   1       consumer accepts on valid&&ready
// - out_data          out  DATA_W  pixel word
// - out_last_pix      out  1       marks pixel K*K-1 of a window
// - out_last_win      out  1       marks last pixel of last window
// BEHAVIOUR
// - Reset (rst=0, async): FSM=IDLE, counters=0; every output 0.
// - FSM: IDLE -start-> RUN; RUN -last read issued-> DRAIN; DRAIN -FIFO empty & no read in flight-> DONE;
//   DONE -> IDLE (done=1 for exactly this cycle). start ignored outside IDLE.
// - Counters: win_r, win_c (window origin), k_r, k_c (offset in window); order k_c fastest, then k_r,
//   then win_c, then win_r. Window count = (IMG_W-K+1)^2 = 144; 9 pixels each -> 1296 words.
// - Pixel addr: read_row_addr = win_r+k_r, read_col_addr = win_c+k_c, zero-extended to 16 bits.
// - Read latency 1: read issued in cycle t -> mem_rdata sampled at end of t+1 into a 2-entry output FIFO.
// - Issue rule: read only if (FIFO count + reads in flight) < 2; no word ever dropped or duplicated.
// - Addresses and layer2_result_read_signal are 0 whenever no read is issued.
// - Latency: start edge -> first read in cycle 1 -> out_valid high in cycle 3 (out_ready held 1).
// - Throughput: 1 word/cycle sustained with out_ready=1.
// - out_valid/out_data/out_last_* held stable until accepted; out_valid never drops without a handshake.
// - out_last_pix/out_last_win travel with their word through the FIFO.
// - Reset mid-pass: immediate abort to IDLE, FIFO flushed, no done pulse.
// CONFIGURATION
// - LAYER3_ZERO_PAD_EN defined: pad 1 on every side; window origins range -1..IMG_W-K+1
//   -> 14x14 = 196 windows, 1764 words.
// - With padding, out-of-range pixels issue no read; a zero word (tagged) enters the same 1-cycle
//   return slot, so pixel order is preserved and the issue rule still applies.
// - LAYER3_ZERO_PAD_EN undefined: no padding, 144 windows; padding logic absent.
// TESTING
// - Memory preloaded word(r,c)=r*14+c; start, out_ready=1 -> 1296 words; first window =
//   0,1,2,14,15,16,28,29,30; done exactly 1 cycle after last handshake.
// - Boundary: last window (origin 11,11) words 165,166,167,179,180,181,193,194,195;
//   out_last_win on 195 only; out_last_pix every 9th word.
// - Backpressure: out_ready random 30% -> identical sequence to unstalled run;
//   never more than 2 words buffered; data stable while stalled.
// - Reset mid-pass after word 500: all outputs 0 during reset; no done pulse;
//   new start after release -> full sequence again from word 0.
// - start pulsed while busy -> ignored; sequence and done timing unchanged.
// - LAYER3_ZERO_PAD_EN: first window = 0,0,0,0,0,1,0,14,15; no read issued for pad pixels;
//   1764 words total.

Source files
------------

// File: rtl/layer3_window_fetcher.sv
// Walks every KxK window of the layer2 result map in raster order, reads each pixel from the
// one-side memory and streams it to the layer3 conv engine. Optional feature: LAYER3_ZERO_PAD_EN.
module layer3_window_fetcher #(
  parameter int unsigned IMG_W  = 14,
  parameter int unsigned K      = 3,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       read_row_addr,
  output logic [15:0]       read_col_addr,
  output logic              layer2_result_read_signal,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last_pix,
  output logic              out_last_win
);

`ifdef LAYER3_ZERO_PAD_EN
  localparam int unsigned PAD = 1;
`else
  localparam int unsigned PAD = 0;
`endif
  localparam int unsigned NWIN = IMG_W - K + 1 + 2 * PAD;
  localparam int unsigned CW   = $clog2(IMG_W + 2);
  localparam int unsigned SW   = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] win_r_q, win_c_q, k_r_q, k_c_q;

  // Read issued last cycle: its word is on mem_rdata now and enters the FIFO at this edge
  logic pend_q, pend_lp_q, pend_lw_q;

  // Second FIFO slot; the first slot is the output register itself
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_lp_q, s1_lw_q;

  logic              pop_c, issue_c, rd_en_c, pad_pix_c;
  logic              last_pix_c, last_win_c;
  logic [1:0]        occ_c;
  logic [SW-1:0]     row_sum_c, col_sum_c, row_addr_c, col_addr_c;
  logic [DATA_W-1:0] push_data_c;

  assign pop_c = out_valid & out_ready;

  // Slots committed after this cycle's pop: FIFO words plus the word returning now
  assign occ_c = 2'(out_valid) + 2'(s1_valid_q) + 2'(pend_q) - 2'(pop_c);

  assign last_pix_c = (k_r_q == CW'(K - 1)) && (k_c_q == CW'(K - 1));
  assign last_win_c = last_pix_c && (win_r_q == CW'(NWIN - 1)) && (win_c_q == CW'(NWIN - 1));

  assign row_sum_c  = {1'b0, win_r_q} + {1'b0, k_r_q};
  assign col_sum_c  = {1'b0, win_c_q} + {1'b0, k_c_q};
  assign row_addr_c = row_sum_c - SW'(PAD);
  assign col_addr_c = col_sum_c - SW'(PAD);

`ifdef LAYER3_ZERO_PAD_EN
  logic pend_zero_q;

  // Padded coordinates 0 and IMG_W+1 fall outside the real map
  assign pad_pix_c = (row_sum_c == '0) || (row_sum_c > SW'(IMG_W)) ||
                     (col_sum_c == '0) || (col_sum_c > SW'(IMG_W));
  assign push_data_c = pend_zero_q ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_zero_q <= 1'b0;
    else      pend_zero_q <= issue_c & pad_pix_c;
  end
`else
  assign pad_pix_c   = 1'b0;
  assign push_data_c = mem_rdata;
`endif

  // Next state plus the combinational read-port drive
  always_comb begin
    state_d                   = state_q;
    issue_c                   = 1'b0;
    rd_en_c                   = 1'b0;
    read_row_addr             = '0;
    read_col_addr             = '0;
    layer2_result_read_signal = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        issue_c = (occ_c < 2'd2);
        rd_en_c = issue_c && !pad_pix_c;
        if (issue_c && last_win_c) state_d = S_DRAIN;
      end
      S_DRAIN: if (!pend_q && !s1_valid_q && (!out_valid || out_ready)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rd_en_c) begin
      layer2_result_read_signal = 1'b1;
      read_row_addr             = 16'(row_addr_c);
      read_col_addr             = 16'(col_addr_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
    end
  end

  // Window walk: k_c fastest, then k_r, then win_c, then win_r
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r_q <= '0;
      win_c_q <= '0;
      k_r_q   <= '0;
      k_c_q   <= '0;
    end else if (state_q == S_IDLE) begin
      win_r_q <= '0;
      win_c_q <= '0;
      k_r_q   <= '0;
      k_c_q   <= '0;
    end else if (issue_c) begin
      if (k_c_q != CW'(K - 1)) begin
        k_c_q <= k_c_q + CW'(1);
      end else begin
        k_c_q <= '0;
        if (k_r_q != CW'(K - 1)) begin
          k_r_q <= k_r_q + CW'(1);
        end else begin
          k_r_q <= '0;
          if (win_c_q != CW'(NWIN - 1)) begin
            win_c_q <= win_c_q + CW'(1);
          end else begin
            win_c_q <= '0;
            win_r_q <= (win_r_q == CW'(NWIN - 1)) ? '0 : win_r_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= 1'b0;
      pend_lp_q <= 1'b0;
      pend_lw_q <= 1'b0;
    end else begin
      pend_q    <= issue_c;
      pend_lp_q <= issue_c & last_pix_c;
      pend_lw_q <= issue_c & last_win_c;
    end
  end

  // Two-entry FIFO: head lives in the output registers, s1 behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last_pix <= 1'b0;
      out_last_win <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_lp_q      <= 1'b0;
      s1_lw_q      <= 1'b0;
    end else if (pop_c) begin
      if (s1_valid_q) begin
        out_data     <= s1_data_q;
        out_last_pix <= s1_lp_q;
        out_last_win <= s1_lw_q;
        s1_valid_q   <= pend_q;
        if (pend_q) begin
          s1_data_q <= push_data_c;
          s1_lp_q   <= pend_lp_q;
          s1_lw_q   <= pend_lw_q;
        end
      end else begin
        out_valid <= pend_q;
        if (pend_q) begin
          out_data     <= push_data_c;
          out_last_pix <= pend_lp_q;
          out_last_win <= pend_lw_q;
        end
      end
    end else if (pend_q) begin
      if (!out_valid) begin
        out_valid    <= 1'b1;
        out_data     <= push_data_c;
        out_last_pix <= pend_lp_q;
        out_last_win <= pend_lw_q;
      end else begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= push_data_c;
        s1_lp_q    <= pend_lp_q;
        s1_lw_q    <= pend_lw_q;
      end
    end
  end

endmodule

// File: tb/tb_layer3_window_fetcher.sv
// Scoreboard bench for layer3_window_fetcher: a loop-based window model fills an expected queue,
// a negedge monitor pops and compares every handshake and polices the read port.
module tb_layer3_window_fetcher;
  localparam int IMG_W  = 14;
  localparam int K      = 3;
  localparam int DATA_W = 128;
`ifdef LAYER3_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int NWIN  = IMG_W - K + 1 + 2 * PAD;
  localparam int TOTAL = NWIN * NWIN * K * K;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, done, layer2_result_read_signal;
  logic              out_valid, out_last_pix, out_last_win;
  logic [15:0]       read_row_addr, read_col_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] out_data;

  layer3_window_fetcher #(.IMG_W(IMG_W), .K(K), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .layer2_result_read_signal(layer2_result_read_signal), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_pix(out_last_pix), .out_last_win(out_last_win)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              lp;
    logic              lw;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e;
  int                seen_q[$];
  logic [DATA_W-1:0] mem [IMG_W][IMG_W];
  int                checks = 0;
  int                errors = 0;
  int                hs_cnt = 0;
  int                rd_cnt = 0;
  int                done_cnt = 0;
  int                exp_reads = 0;
  bit                exp_done = 1'b0;
  bit                rand_ready = 1'b0;
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_lp = 1'b0;
  logic              prev_lw = 1'b0;
  int                first_exp[9];
  int                last_exp[9];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: every window, every pixel, straight from the map definition
  task automatic push_pass();
    int  r;
    int  c;
    bit  inr;
    exp_t x;
    exp_reads = 0;
    for (int wr = 0; wr < NWIN; wr++)
      for (int wc = 0; wc < NWIN; wc++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            r    = wr + kr - PAD;
            c    = wc + kc - PAD;
            inr  = (r >= 0) && (r < IMG_W) && (c >= 0) && (c < IMG_W);
            x.data = inr ? mem[r][c] : '0;
            x.lp   = (kr == K - 1) && (kc == K - 1);
            x.lw   = x.lp && (wr == NWIN - 1) && (wc == NWIN - 1);
            if (inr) exp_reads++;
            exp_q.push_back(x);
          end
  endtask

  // Memory with one-cycle read latency; garbage whenever nothing is read
  always @(posedge clk) begin
    if (layer2_result_read_signal && read_row_addr < 16'(IMG_W) && read_col_addr < 16'(IMG_W))
      mem_rdata <= mem[int'(read_row_addr)][int'(read_col_addr)];
    else
      mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (done || exp_done) check("done_timing", DATA_W'(done), DATA_W'(exp_done));
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (stall_prev) begin
        check("stall_valid", DATA_W'(out_valid), DATA_W'(1));
        check("stall_data", out_data, prev_data);
        check("stall_tags", DATA_W'({out_last_pix, out_last_win}), DATA_W'({prev_lp, prev_lw}));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        seen_q.push_back(int'(out_data[15:0]));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e.data);
          check("word_last_pix", DATA_W'(out_last_pix), DATA_W'(e.lp));
          check("word_last_win", DATA_W'(out_last_win), DATA_W'(e.lw));
          if (e.lw) exp_done = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_lp    = out_last_pix;
      prev_lw    = out_last_win;
      if (layer2_result_read_signal) begin
        rd_cnt++;
        check("read_addr_range", DATA_W'((read_row_addr < 16'(IMG_W)) && (read_col_addr < 16'(IMG_W))), DATA_W'(1));
        check("buffered_le2", DATA_W'((rd_cnt - hs_cnt) <= 2), DATA_W'(1));
      end else begin
        check("idle_addr_zero", DATA_W'({read_row_addr, read_col_addr}), '0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, DATA_W'(busy), '0);
    check({tag, "_done"}, DATA_W'(done), '0);
    check({tag, "_rd"}, DATA_W'(layer2_result_read_signal), '0);
    check({tag, "_addr"}, DATA_W'({read_row_addr, read_col_addr}), '0);
    check({tag, "_valid"}, DATA_W'(out_valid), '0);
    check({tag, "_data"}, out_data, '0);
    check({tag, "_tags"}, DATA_W'({out_last_pix, out_last_win}), '0);
  endtask

  task automatic arm_pass();
    exp_q.delete();
    seen_q.delete();
    hs_cnt   = 0;
    rd_cnt   = 0;
    done_cnt = 0;
    push_pass();
  endtask

  task automatic do_start();
    arm_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_pass(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 10000 cycles", name);
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_busy_low"}, DATA_W'(busy), '0);
    check({name, "_queue_empty"}, DATA_W'(exp_q.size()), '0);
    check({name, "_words"}, DATA_W'(hs_cnt), DATA_W'(TOTAL));
    check({name, "_reads"}, DATA_W'(rd_cnt), DATA_W'(exp_reads));
    check({name, "_one_done"}, DATA_W'(done_cnt), DATA_W'(1));
    if (seen_q.size() >= 9)
      for (int i = 0; i < 9; i++) begin
        check({name, "_first_win"}, DATA_W'(seen_q[i]), DATA_W'(first_exp[i]));
        check({name, "_last_win"}, DATA_W'(seen_q[seen_q.size() - 9 + i]), DATA_W'(last_exp[i]));
      end
  endtask

  initial begin
    int n;
`ifdef LAYER3_ZERO_PAD_EN
    first_exp = '{0, 0, 0, 0, 0, 1, 0, 14, 15};
    last_exp  = '{180, 181, 0, 194, 195, 0, 0, 0, 0};
`else
    first_exp = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    last_exp  = '{165, 166, 167, 179, 180, 181, 193, 194, 195};
`endif
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        mem[r][c] = DATA_W'(r * IMG_W + c);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Pass A: no backpressure, latency and ordering
    arm_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("lat_read_c1", DATA_W'(layer2_result_read_signal), DATA_W'(PAD == 0));
    check("lat_busy_c1", DATA_W'(busy), DATA_W'(1));
    check("lat_valid_c1", DATA_W'(out_valid), '0);
    @(negedge clk);
    check("lat_valid_c2", DATA_W'(out_valid), '0);
    @(negedge clk);
    check("lat_valid_c3", DATA_W'(out_valid), DATA_W'(1));
    wait_pass("passA");

    // Pass B: random backpressure plus a stray start while busy
    rand_ready = 1'b1;
    do_start();
    repeat (100) @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_pass("passB");

    // Pass C: abort with reset after word 500, then a complete pass
    do_start();
    n = 0;
    while (hs_cnt < 500 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hs_cnt < 500) begin
      errors++;
      $display("FAIL abort_reach500: got %0d words expected 500", hs_cnt);
    end
    #2 rst = 1'b0;
    #1 check_all_zero("abort_reset");
    repeat (3) @(negedge clk);
    check("abort_hold_valid", DATA_W'(out_valid), '0);
    exp_q.delete();
    exp_done = 1'b0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", DATA_W'(done_cnt), '0);
    check("abort_idle", DATA_W'(busy), '0);
    do_start();
    wait_pass("passC");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
